// File: rtl/exec_trace_pkg.sv
// Shared state/status encodings and helpers for the execution trace monitor.
package exec_trace_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_DONE    = 2'd2;
    localparam state_t ST_TIMEOUT = 2'd3;

    localparam int unsigned DROP_W = 8;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with flush, occupancy level and wrap-around pointers.
// DEPTH must be a power of two; a push when full is accepted only alongside a pop.
module trace_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: validity is tracked by level_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/exec_trace_monitor.sv
// Captures retiring instructions into a trace FIFO during a run, with watchdog and drop accounting.
// Define EXEC_TRACE_RF_FILTER_EN to capture only commits that write the register file.
module exec_trace_monitor
    import exec_trace_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TO_W   = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         commit_valid,
    input  logic [PC_W-1:0]              commit_pc,
    input  logic                         commit_rf_we,
    input  logic [DATA_W-1:0]            commit_rf_data,
    input  logic                         cpu_done,
    input  logic [TO_W-1:0]              timeout_limit,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [PC_W+DATA_W:0]         trace_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [1:0]                   status,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);
    localparam int unsigned ENTRY_W = PC_W + DATA_W + 1;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               flush_c, capture_c, pop_c, drop_c, commit_en_c;
    logic               fifo_full, fifo_empty;

`ifdef EXEC_TRACE_RF_FILTER_EN
    assign commit_en_c = commit_valid & commit_rf_we;
`else
    assign commit_en_c = commit_valid;
`endif

    assign capture_c = (state_q == ST_RUN) & commit_en_c;
    assign pop_c     = ~fifo_empty & trace_ready;
    assign drop_c    = capture_c & fifo_full & ~pop_c;

    // Next state; cpu_done takes priority over the watchdog.
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        flush_c    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                wd_d = wd_q + TO_W'(1);
                if (cpu_done) begin
                    state_d = ST_DONE;
                end else if ((timeout_limit != '0) && (wd_q == timeout_limit)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    flush_c    = 1'b1;
                    wd_d       = '0;
                    overflow_d = 1'b0;
                    drop_d     = '0;
                end
            end
        endcase
        if (drop_c) begin
            overflow_d = 1'b1;
            drop_d     = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wd_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (flush_c),
        .push_i  (capture_c),
        .pop_i   (pop_c),
        .wdata_i ({commit_rf_we, commit_pc, commit_rf_data}),
        .rdata_o (trace_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign trace_valid = ~fifo_empty;
    assign status      = state_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Scoreboard bench for exec_trace_monitor: expected entries queued on capture, checked on pop.
module tb_exec_trace_monitor;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TO_W    = 20;
    localparam int unsigned ENTRY_W = PC_W + DATA_W + 1;
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);

    typedef logic [ENTRY_W-1:0] entry_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               commit_valid;
    logic [PC_W-1:0]    commit_pc;
    logic               commit_rf_we;
    logic [DATA_W-1:0]  commit_rf_data;
    logic               cpu_done;
    logic [TO_W-1:0]    timeout_limit;
    logic               trace_valid;
    logic               trace_ready;
    logic [ENTRY_W-1:0] trace_data;
    logic [LVL_W-1:0]   level;
    logic [1:0]         status;
    logic               overflow;
    logic [7:0]         drop_cnt;

    entry_t sb[$];
    entry_t exp_e;
    int     n_checks = 0;
    int     n_pass   = 0;

    exec_trace_monitor #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TO_W   (TO_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_rf_we   (commit_rf_we),
        .commit_rf_data (commit_rf_data),
        .cpu_done       (cpu_done),
        .timeout_limit  (timeout_limit),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .level          (level),
        .status         (status),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pops are observed mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (reset && trace_valid && trace_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL trace_unexpected: got %h, expected no entry", trace_data);
            end else begin
                exp_e = sb.pop_front();
                if (trace_data !== exp_e)
                    $display("FAIL trace_data: got %h, expected %h", trace_data, exp_e);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        sb.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_commit(input logic [7:0] pc, input logic [7:0] d, input bit expect_cap);
        commit_valid   = 1'b1;
        commit_pc      = pc;
        commit_rf_data = d;
        commit_rf_we   = 1'b1;
        if (expect_cap) sb.push_back({1'b1, pc, d});
    endtask

    task automatic finish_run();
        commit_valid = 1'b0;
        cpu_done     = 1'b1;
        tick();
        cpu_done = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        trace_ready = 1'b1;
        while ((level !== '0 || sb.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        trace_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (status !== 2'd0 || level !== '0 || trace_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL reset_state: got st=%0d lvl=%0d v=%b ovf=%b drop=%0d, expected 0/0/0/0/0",
                     status, level, trace_valid, overflow, drop_cnt);
        else n_pass++;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        trace_ready = 1'b1;
        start_run();
        n_checks++;
        if (status !== 2'd1) $display("FAIL basic_run: got status %0d, expected 1", status);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_commit(8'(i), 8'(5 + i), 1'b1);
            if (i == 0) begin
                n_checks++;
                if (trace_valid !== 1'b0) $display("FAIL no_bypass: got valid %b, expected 0", trace_valid);
                else n_pass++;
            end
            tick();
        end
        commit_valid = 1'b0;
        drain();
        n_checks++;
        if (level !== '0 || sb.size() != 0)
            $display("FAIL basic_drain: got level %0d pending %0d, expected 0/0", level, sb.size());
        else n_pass++;
        finish_run();
        n_checks++;
        if (status !== 2'd2) $display("FAIL basic_done: got status %0d, expected 2", status);
        else n_pass++;
    endtask

    task automatic test_overflow();
        entry_t head;
        trace_ready = 1'b0;
        start_run();
        for (int i = 0; i < 20; i++) begin
            drive_commit(8'(8'h20 + i), 8'(8'hA0 + i), i < 16);
            tick();
        end
        commit_valid = 1'b0;
        n_checks++;
        if (level !== LVL_W'(16) || overflow !== 1'b1 || drop_cnt !== 8'd4)
            $display("FAIL overflow_state: got lvl=%0d ovf=%b drop=%0d, expected 16/1/4", level, overflow, drop_cnt);
        else n_pass++;
        head = {1'b1, 8'h20, 8'hA0};
        tick();
        tick();
        n_checks++;
        if (trace_valid !== 1'b1 || trace_data !== head)
            $display("FAIL hold_stable: got v=%b data=%h, expected 1/%h", trace_valid, trace_data, head);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        drive_commit(8'h40, 8'hC0, 1'b1);
        trace_ready = 1'b1;
        tick();
        commit_valid = 1'b0;
        trace_ready  = 1'b0;
        n_checks++;
        if (level !== LVL_W'(16) || drop_cnt !== 8'd4)
            $display("FAIL full_pushpop: got lvl=%0d drop=%0d, expected 16/4", level, drop_cnt);
        else n_pass++;
        finish_run();
        drain();
        n_checks++;
        if (level !== '0 || sb.size() != 0 || status !== 2'd2)
            $display("FAIL done_drain: got lvl=%0d pending=%0d st=%0d, expected 0/0/2", level, sb.size(), status);
        else n_pass++;
    endtask

    task automatic test_timeout();
        timeout_limit = TO_W'(100);
        start_run();
        repeat (100) tick();
        n_checks++;
        if (status !== 2'd1) $display("FAIL timeout_early: got status %0d, expected 1", status);
        else n_pass++;
        tick();
        n_checks++;
        if (status !== 2'd3) $display("FAIL timeout_fire: got status %0d, expected 3", status);
        else n_pass++;
        timeout_limit = '0;
        start_run();
        repeat (200) tick();
        n_checks++;
        if (status !== 2'd1) $display("FAIL timeout_disabled: got status %0d, expected 1", status);
        else n_pass++;
        finish_run();
    endtask

    task automatic test_done_on_limit();
        timeout_limit = TO_W'(10);
        start_run();
        repeat (10) tick();
        drive_commit(8'h77, 8'h99, 1'b1);
        cpu_done = 1'b1;
        tick();
        commit_valid = 1'b0;
        cpu_done     = 1'b0;
        n_checks++;
        if (status !== 2'd2 || level !== LVL_W'(1))
            $display("FAIL done_priority: got st=%0d lvl=%0d, expected 2/1", status, level);
        else n_pass++;
        drain();
        n_checks++;
        if (level !== '0 || sb.size() != 0)
            $display("FAIL done_capture: got lvl=%0d pending=%0d, expected 0/0", level, sb.size());
        else n_pass++;
        timeout_limit = '0;
    endtask

    task automatic test_saturate();
        start_run();
        for (int i = 0; i < 272; i++) begin
            drive_commit(8'(i), 8'(~i), i < 16);
            tick();
        end
        commit_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1)
            $display("FAIL drop_saturate: got drop=%0d ovf=%b, expected 255/1", drop_cnt, overflow);
        else n_pass++;
        finish_run();
        start_run();
        n_checks++;
        if (level !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || status !== 2'd1)
            $display("FAIL restart_clear: got lvl=%0d ovf=%b drop=%0d st=%0d, expected 0/0/0/1",
                     level, overflow, drop_cnt, status);
        else n_pass++;
        finish_run();
    endtask

    task automatic test_reset_midrun();
        start_run();
        for (int i = 0; i < 5; i++) begin
            drive_commit(8'(8'h50 + i), 8'(i), 1'b1);
            tick();
        end
        commit_valid = 1'b0;
        n_checks++;
        if (level !== LVL_W'(5)) $display("FAIL midrun_level: got %0d, expected 5", level);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (level !== '0 || status !== 2'd0 || trace_valid !== 1'b0)
            $display("FAIL async_reset: got lvl=%0d st=%0d v=%b, expected 0/0/0", level, status, trace_valid);
        else n_pass++;
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (status !== 2'd0 || level !== '0) $display("FAIL post_reset: got st=%0d lvl=%0d, expected 0/0", status, level);
        else n_pass++;
    endtask

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        commit_valid   = 1'b0;
        commit_pc      = '0;
        commit_rf_we   = 1'b0;
        commit_rf_data = '0;
        cpu_done       = 1'b0;
        timeout_limit  = '0;
        trace_ready    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_timeout();
        test_done_on_limit();
        test_saturate();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_trace_monitor.md
EXEC_TRACE_MONITOR -- requirements
Module: exec_trace_monitor

Interface
REQ-001 SHALL have parameter PC_W, default 8, commit PC width.
REQ-002 SHALL have parameter DATA_W, default 8, register-write data width.
REQ-003 SHALL have parameter DEPTH, default 16, trace FIFO entries, power of two and at least 2.
REQ-004 SHALL have parameter TO_W, default 20, watchdog counter width.
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, arms capture for one run.
REQ-008 SHALL have port commit_valid, input, 1, one instruction retires this cycle.
REQ-009 SHALL have port commit_pc, input, PC_W, PC of the retiring instruction.
REQ-010 SHALL have port commit_rf_we, input, 1, retiring instruction writes the register file.
REQ-011 SHALL have port commit_rf_data, input, DATA_W, register-file write value.
REQ-012 SHALL have port cpu_done, input, 1, CPU halt indication.
REQ-013 SHALL have port timeout_limit, input, TO_W, watchdog limit in RUN cycles; 0 disables the watchdog.
REQ-014 SHALL have port trace_valid, output, 1, FIFO head entry available.
REQ-015 SHALL have port trace_ready, input, 1, consumer accepts the head entry.
REQ-016 SHALL have port trace_data, output, PC_W+DATA_W+1, packed {rf_we, pc, data}.
REQ-017 SHALL have port level, output, $clog2(DEPTH+1), FIFO occupancy.
REQ-018 SHALL have port status, output, 2, current state: IDLE=0, RUN=1, DONE=2, TIMEOUT=3.
REQ-019 SHALL have port overflow, output, 1, sticky flag set when any entry has been dropped.
REQ-020 SHALL have port drop_cnt, output, 8, saturating count of dropped entries.

Function
REQ-021 SHALL transition IDLE->RUN on start; start in DONE or TIMEOUT SHALL also enter RUN, flushing the FIFO and clearing overflow, drop_cnt and the watchdog.
REQ-022 SHALL, in RUN, push one entry per cycle when commit_valid=1; SHALL NOT capture in any other state.
REQ-023 SHALL, in RUN, transition to DONE on cpu_done=1; a commit in that same cycle SHALL still be captured.
REQ-024 SHALL increment the watchdog on every RUN cycle; when the watchdog equals timeout_limit (non-zero), the block SHALL move to TIMEOUT on the next edge.
REQ-025 SHALL give cpu_done priority over timeout when both occur in the same cycle.
REQ-026 SHALL complete a pop on a cycle where trace_valid & trace_ready; trace_data SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-027 SHALL, on a push with the FIFO full and no pop, drop the new entry, set overflow, and increment drop_cnt, saturating at 255.
REQ-028 SHALL perform both operations on a simultaneous push and pop when full, with no drop and level unchanged.
REQ-029 SHALL, on a push into an empty FIFO, make the entry visible on the next cycle; there SHALL be no same-cycle bypass.
REQ-030 SHALL keep draining the FIFO in DONE and TIMEOUT until empty.
REQ-031 SHALL wrap the read and write pointers modulo DEPTH; level SHALL range 0..DEPTH.

Reset
REQ-032 SHALL, on reset low, asynchronously force status=IDLE, level=0, trace_valid=0, overflow=0, drop_cnt=0, watchdog=0 and both pointers to 0.
REQ-033 SHALL discard all FIFO contents and abandon any in-flight run on reset asserted mid-run.

Configuration
REQ-034 SHALL, with EXEC_TRACE_RF_FILTER_EN defined, capture only commits with commit_rf_we=1; without it, SHALL capture every valid commit.

Structure
REQ-035 SHALL place the state enum and the status encodings in package exec_trace_pkg.
REQ-036 SHALL implement the FIFO as sub-module trace_fifo (parameters WIDTH and DEPTH) with synchronous push/pop, full/empty and level outputs.

Verification
REQ-037 Bench SHALL cover: start, then 3 commits with PC 0,1,2 and rf_data 5,6,7, trace_ready=1 -> 3 entries out in order, level returns to 0.
REQ-038 Bench SHALL cover: DEPTH=16, trace_ready=0, 20 commits -> level=16, overflow=1, drop_cnt=4; first 16 PCs drain intact.
REQ-039 Bench SHALL cover: FIFO full, commit and pop in the same cycle -> level stays 16, drop_cnt unchanged.
REQ-040 Bench SHALL cover: timeout_limit=100, no cpu_done -> status=3 after 101 RUN cycles; with timeout_limit=0 -> status stays 1.
REQ-041 Bench SHALL cover: cpu_done together with a commit on the watchdog-limit cycle -> status=2 and the final commit captured.
REQ-042 Bench SHALL cover: reset low mid-run with level=5 -> level=0, status=0 immediately, without waiting for a clock edge.
